// File: rtl/matmul_host_sequencer_if.sv
// Bundle of the host operand/result streams and the engine pin interface.
// The master modport is the sequencer; the slave modport is the host plus engine side.
interface matmul_host_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 17
);
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_data;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [1:0]        res_idx;
  logic              busy;
  logic [2:0]        mm_sel_in;
  logic [DATA_W-1:0] mm_input_val;
  logic              mm_execute;
  logic [1:0]        mm_sel_out;
  logic [RES_W-1:0]  mm_result;

  modport master (
    input  op_valid, op_data, res_ready, mm_result,
    output op_ready, res_valid, res_data, res_idx, busy,
           mm_sel_in, mm_input_val, mm_execute, mm_sel_out
  );

  modport slave (
    output op_valid, op_data, res_ready, mm_result,
    input  op_ready, res_valid, res_data, res_idx, busy,
           mm_sel_in, mm_input_val, mm_execute, mm_sel_out
  );
endinterface

// File: rtl/matmul_host_sequencer.sv
// Initiator-side sequencer for the 2x2 matrix-multiply engine: loads eight operand
// bytes with execute low, then reads back the four product elements one by one.
module matmul_host_sequencer #(
  parameter int DATA_W        = 8,
  parameter int RES_W         = 17,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  matmul_host_sequencer_if.master bus
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMMIT  = 2'd1;
  localparam logic [1:0] ST_SETTLE  = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  logic [1:0]        state_r;
  logic [2:0]        cnt_r;
  logic [SW-1:0]     settle_r;
  logic [2:0]        sel_in_r;
  logic [DATA_W-1:0] input_val_r;
  logic              execute_r;
  logic [1:0]        sel_out_r;
  logic              res_valid_r;
  logic [RES_W-1:0]  res_data_r;
  logic [1:0]        res_idx_r;
  logic              busy_r;
  logic              op_ready_s;
  logic              op_fire_s;
  logic              res_fire_s;

  // Operand acceptance is decoded straight from the state so it is ready out of reset.
  always_comb begin
    op_ready_s = 1'b0;
    if (state_r == ST_LOAD) begin
      op_ready_s = 1'b1;
    end else begin
      op_ready_s = 1'b0;
    end
  end

  assign op_fire_s  = bus.op_valid & op_ready_s;
  assign res_fire_s = bus.res_ready & res_valid_r;

  // Main sequencing: load, commit, then settle/present once per product element.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_LOAD;
      cnt_r       <= 3'd0;
      settle_r    <= '0;
      sel_in_r    <= 3'd0;
      input_val_r <= '0;
      execute_r   <= 1'b0;
      sel_out_r   <= 2'd0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_idx_r   <= 2'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (op_fire_s) begin
            sel_in_r    <= cnt_r;
            input_val_r <= bus.op_data;
            cnt_r       <= cnt_r + 3'd1;
            busy_r      <= 1'b1;
            if (cnt_r == 3'd7) begin
              state_r <= ST_COMMIT;
            end
          end
        end
        // The engine still has execute low here and captures the last B byte.
        ST_COMMIT: begin
          execute_r <= 1'b1;
          sel_out_r <= 2'd0;
          res_idx_r <= 2'd0;
          settle_r  <= SETTLE_LOAD;
          state_r   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          settle_r <= settle_r - SW'(1);
          if (settle_r == SW'(1)) begin
            res_data_r  <= bus.mm_result;
            res_valid_r <= 1'b1;
            state_r     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (res_fire_s) begin
            res_valid_r <= 1'b0;
            if (res_idx_r == 2'd3) begin
              // Write select/data keep index 7 and the B11 byte, so dropping execute is benign.
              execute_r <= 1'b0;
              busy_r    <= 1'b0;
              cnt_r     <= 3'd0;
              state_r   <= ST_LOAD;
            end else begin
              sel_out_r <= sel_out_r + 2'd1;
              res_idx_r <= res_idx_r + 2'd1;
              settle_r  <= SETTLE_LOAD;
              state_r   <= ST_SETTLE;
            end
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

  assign bus.op_ready     = op_ready_s;
  assign bus.res_valid    = res_valid_r;
  assign bus.res_data     = res_data_r;
  assign bus.res_idx      = res_idx_r;
  assign bus.busy         = busy_r;
  assign bus.mm_sel_in    = sel_in_r;
  assign bus.mm_input_val = input_val_r;
  assign bus.mm_execute   = execute_r;
  assign bus.mm_sel_out   = sel_out_r;

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Bench for matmul_host_sequencer: behavioural 2x2 engine on the pin side,
// matrix products computed from the loaded operands as the reference.
module tb_matmul_host_sequencer;

  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matmul_host_sequencer_if #(.DATA_W(8), .RES_W(17)) bus();

  matmul_host_sequencer #(.DATA_W(8), .RES_W(17), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Engine model: writes while execute is low, combinational product read-out.
  logic [7:0] eng [0:7];
  always @(posedge clk) begin
    if (!bus.mm_execute) eng[bus.mm_sel_in] <= bus.mm_input_val;
  end

  function automatic logic [16:0] mm_elem(input logic [7:0] a0, a1, b0, b1);
    return 17'(a0) * 17'(b0) + 17'(a1) * 17'(b1);
  endfunction

  logic [1:0] so;
  assign so = bus.mm_sel_out;
  assign bus.mm_result = mm_elem(eng[{1'b0, so[1], 1'b0}], eng[{1'b0, so[1], 1'b1}],
                                 eng[{2'b10, so[0]}], eng[{2'b11, so[0]}]);

  int   ops [8];
  int   n_checks = 0;
  int   n_fail = 0;
  int   stray = 0;
  logic in_exec = 1'b0;

  // Operands offered after the 8th accept and before the last result must never be taken.
  always @(posedge clk) begin
    if (in_exec && bus.op_valid && bus.op_ready) stray <= stray + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_c(input int e);
    int i = e / 2;
    int j = e % 2;
    return ops[2*i] * ops[4+j] + ops[2*i+1] * ops[6+j];
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_op_ready"}, 32'(bus.op_ready), 32'd1);
    check_val({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_execute"}, 32'(bus.mm_execute), 32'd0);
    check_val({tag, "_sel_out"}, 32'(bus.mm_sel_out), 32'd0);
    check_val({tag, "_res_idx"}, 32'(bus.res_idx), 32'd0);
    check_val({tag, "_res_data"}, 32'(bus.res_data), 32'd0);
    check_val({tag, "_sel_in"}, 32'(bus.mm_sel_in), 32'd0);
    check_val({tag, "_input_val"}, 32'(bus.mm_input_val), 32'd0);
  endtask

  task automatic load_ops(input int max_gap);
    int early_valid = 0;
    for (int k = 0; k < 8; k++) begin
      int gap = $urandom_range(0, max_gap);
      bus.op_valid = 1'b0;
      repeat (gap) begin
        tick();
        if (bus.res_valid) early_valid++;
      end
      bus.op_valid = 1'b1;
      bus.op_data  = ops[k][7:0];
      if (!bus.op_ready) check_val("op_ready_in_load", 32'(bus.op_ready), 32'd1);
      tick();
      if (bus.res_valid) early_valid++;
    end
    bus.op_valid = 1'b0;
    in_exec = 1'b1;
    check_val("no_res_during_load", 32'(early_valid), 32'd0);
  endtask

  // hold >= 0: fixed res_ready-low cycles per element; hold < 0: random 0..4.
  task automatic collect(input int hold, input bit noise);
    for (int e = 0; e < 4; e++) begin
      int w = 0;
      int h = (hold < 0) ? int'($urandom_range(0, 4)) : hold;
      bus.res_ready = (h == 0);
      while (!bus.res_valid && w < 100) begin
        if (noise) begin
          bus.op_valid = 1'($urandom);
          bus.op_data  = 8'($urandom);
        end
        tick();
        w++;
      end
      if (w >= 100) begin
        check_val("res_valid_timeout", 32'd0, 32'd1);
        bus.op_valid = 1'b0;
        in_exec = 1'b0;
        return;
      end
      check_val("result_latency", 32'(w), (e == 0) ? 32'(SETTLE + 1) : 32'(SETTLE));
      if (e == 0) begin
        for (int k = 0; k < 8; k++) check_val("engine_contents", 32'(eng[k]), 32'(ops[k]));
      end
      check_val("res_idx", 32'(bus.res_idx), 32'(e));
      check_val("res_data", 32'(bus.res_data), 32'(exp_c(e)));
      check_val("busy_during_read", 32'(bus.busy), 32'd1);
      check_val("execute_during_read", 32'(bus.mm_execute), 32'd1);
      check_val("op_ready_during_read", 32'(bus.op_ready), 32'd0);
      if (h > 0) begin
        logic [16:0] d0 = bus.res_data;
        logic [1:0]  i0 = bus.res_idx;
        int bad = 0;
        repeat (h) begin
          if (noise) bus.op_valid = 1'($urandom);
          tick();
          if (!bus.res_valid || bus.res_data !== d0 || bus.res_idx !== i0) bad++;
        end
        check_val("hold_stable", 32'(bad), 32'd0);
        bus.res_ready = 1'b1;
      end
      tick();
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    check_val("end_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("end_busy", 32'(bus.busy), 32'd0);
    check_val("end_execute", 32'(bus.mm_execute), 32'd0);
    check_val("end_op_ready", 32'(bus.op_ready), 32'd1);
    check_val("end_sel_in", 32'(bus.mm_sel_in), 32'd7);
    check_val("end_input_val", 32'(bus.mm_input_val), 32'(ops[7]));
    check_val("stray_accepts", 32'(stray), 32'd0);
    in_exec = 1'b0;
  endtask

  task automatic set_ops(input int a0, a1, a2, a3, b0, b1, b2, b3);
    ops[0] = a0; ops[1] = a1; ops[2] = a2; ops[3] = a3;
    ops[4] = b0; ops[5] = b1; ops[6] = b2; ops[7] = b3;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_data   = 8'd0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    check_idle("in_reset");
    reset = 1'b0;
    tick();
    check_idle("after_reset");

    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    load_ops(0);
    collect(0, 1'b0);

    set_ops(255, 255, 255, 255, 255, 255, 255, 255);
    load_ops(0);
    collect(0, 1'b0);

    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    load_ops(0);
    collect(5, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 8; k++) ops[k] = int'($urandom_range(0, 255));
      load_ops(3);
      collect(-1, 1'b1);
    end

    // Asynchronous reset while the second element is being presented.
    begin
      int w = 0;
      set_ops(1, 2, 3, 4, 5, 6, 7, 8);
      load_ops(1);
      bus.res_ready = 1'b1;
      while (!(bus.res_valid && bus.res_idx == 2'd1) && w < 100) begin
        tick();
        w++;
      end
      check_val("reach_idx1", 32'(w < 100), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_idle("async_reset");
      bus.res_ready = 1'b0;
      in_exec = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_idle("post_reset");
    end

    set_ops(1, 0, 0, 1, 9, 8, 7, 6);
    load_ops(2);
    collect(-1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_host_sequencer.md
Name: matmul_host_sequencer

Overview:
Initiator-side sequencer for the 2x2 8-bit matrix-multiply engine's pin interface (sel_in / input_val / execute / sel_out / result).
- Accepts eight operand bytes on a valid/ready stream and writes them into the engine with execute low.
- Raises execute, then steps sel_out 0..3, samples each 17-bit product element and returns it on a valid/ready result stream.
- Sits between a host-facing front end (Wishbone/LA glue) and the multiplier core.

Parameters:
DATA_W, 8, operand width; must match the engine's input_val width.
RES_W, 17, result width; must match the engine's result width.
SETTLE_CYCLES, 1, cycles (>=1) between driving mm_sel_out and sampling mm_result.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
op_valid  input  1  operand byte valid.
op_ready  output  1  sequencer accepts operand this cycle.
op_data  input  DATA_W  operand byte; order A00,A01,A10,A11,B00,B01,B10,B11.
res_valid  output  1  result element valid.
res_ready  input  1  consumer accepts result.
res_data  output  RES_W  sampled C element.
res_idx  output  2  element index: 0=C00, 1=C01, 2=C10, 3=C11.
busy  output  1  high from first operand accept until last result handshake.
mm_sel_in  output  3  engine write select.
mm_input_val  output  DATA_W  engine write data.
mm_execute  output  1  engine execute: 0=load, 1=read.
mm_sel_out  output  2  engine read select.
mm_result  input  RES_W  engine product output.

Behaviour:
- All mm_* outputs, res_data and res_idx are registered.
- Reset values: state LOAD, op count 0, mm_sel_in=0, mm_input_val=0, mm_execute=0, mm_sel_out=0, res_valid=0, res_data=0, res_idx=0, busy=0.
- op_ready = (state==LOAD); combinational from state, so it is 1 immediately after reset releases.
- LOAD state:
  - On op_valid&op_ready: mm_sel_in<=cnt, mm_input_val<=op_data, cnt<=cnt+1, busy<=1.
  - If cnt==7, go to COMMIT.
  - op_valid gaps are allowed. While waiting, mm_sel_in and mm_input_val hold their last values; the engine rewriting the same value is harmless.
- COMMIT (exactly 1 cycle):
  - op_ready=0; the engine captures B11 on this edge.
  - Then mm_execute<=1, mm_sel_out<=0, res_idx<=0, settle counter<=SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - On the edge where the counter reaches 0: res_data<=mm_result, res_valid<=1, go to PRESENT.
- PRESENT:
  - Hold res_data, res_idx and res_valid stable until res_ready.
  - On handshake with res_idx<3: res_valid<=0, mm_sel_out<=mm_sel_out+1, res_idx<=res_idx+1, reload the counter, go to SETTLE.
  - On handshake with res_idx==3: res_valid<=0, mm_execute<=0, busy<=0, cnt<=0, go to LOAD.
  - mm_sel_in and mm_input_val keep their values (index 7, last B11 byte), so returning execute low does not corrupt the engine.
- Latency (SETTLE_CYCLES=1):
  - res_valid asserts after the 2nd rising edge following the edge that accepts the 8th operand.
  - With res_ready held high, one result every 2 cycles.
  - In general, each result takes SETTLE_CYCLES+1 cycles.
- Width: res_data is mm_result passed through unmodified. The maximum value 2*255*255 = 130050 (0x1FC02) fits in 17 bits.
- Reset mid-operation: asynchronously returns every register to its reset value; partial operand count and any pending result are discarded. The next load writes all 8 entries, so stale engine contents never leak into results.
- res_ready high while res_valid low has no effect. op_valid outside LOAD is ignored and is not counted.

Test Plan:
- Load A=[[1,2],[3,4]], B=[[5,6],[7,8]] with res_ready=1 -> results (idx,data) = (0,19), (1,22), (2,43), (3,50) on consecutive 2-cycle slots; busy falls after idx 3; mm_execute returns to 0.
- Load all operands 255 -> all four results 130050 (0x1FC02); no truncation.
- Same load as scenario 1 with res_ready held low 5 cycles per element -> res_data/res_idx stay stable while res_valid=1; no element skipped or repeated.
- Operands with random 0-3 cycle op_valid gaps -> the engine-model write sequence is exactly indices 0..7 with correct bytes; op_ready stays 0 from COMMIT until the final result handshake.
- Assert reset during PRESENT at idx 1, then load A=identity, B=[[9,8],[7,6]] -> no res_valid until the new load completes; results 9, 8, 7, 6.
- Drive op_valid=1 during SETTLE/PRESENT -> no operand accepted, cnt unchanged, engine sees no writes while mm_execute=1.
